// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding uart_tx through the tx_start/tx_data/tx_done handshake.
// Optional sticky overflow flag: define UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overflow,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  state_t state_reg, state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp_reg, rp_reg;
  logic [ADDR_W:0]   count_reg;
  logic [DATA_W-1:0] tx_data_reg;
  logic              tx_start_reg;
  logic              pop;
  logic              push;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == FULL_COUNT);
  assign count    = count_reg;
  assign busy     = !empty || (state_reg == SEND);
  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;

  // A pop frees a slot on the same edge, so a write while full is still accepted.
  assign push = wr_en && (!full || pop);

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        // tx_done coinciding with our own start pulse cannot belong to this frame.
        if (tx_done && !tx_start_reg) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_reg       <= '0;
      rp_reg       <= '0;
      count_reg    <= '0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
    end else begin
      tx_start_reg <= pop;
      if (push) begin
        wp_reg <= wp_reg + 1'b1;
      end
      if (pop) begin
        tx_data_reg <= mem[rp_reg];
        rp_reg      <= rp_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic overflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (wr_en && full && !pop) begin
      overflow_reg <= 1'b1;
    end
  end

  assign overflow = overflow_reg;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo; a queue scoreboard predicts each popped byte and the flags.
module tb_uart_tx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              tx_done = 1'b0;
  logic              full, empty, busy, overflow, tx_start;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] tx_data;

  uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .busy(busy),
    .overflow(overflow), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard: bytes accepted but not yet handed to uart_tx, plus the handshake status.
  logic [DATA_W-1:0] q[$];
  logic              m_send = 1'b0;
  logic              m_ts   = 1'b0;
  logic [DATA_W-1:0] m_data = '0;
  logic              m_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    chk({step, ":tx_start"}, 32'(tx_start), 32'(m_ts));
    chk({step, ":tx_data"},  32'(tx_data),  32'(m_data));
    chk({step, ":count"},    32'(count),    32'(q.size()));
    chk({step, ":empty"},    32'(empty),    32'(q.size() == 0));
    chk({step, ":full"},     32'(full),     32'(q.size() == DEPTH));
    chk({step, ":busy"},     32'(busy),     32'((q.size() != 0) || m_send));
    chk({step, ":overflow"}, 32'(overflow), 32'(m_ovf));
    $display("step %s wr=%0b d=%02h done=%0b -> start=%0b data=%02h count=%0d busy=%0b ovf=%0b",
             step, wr_en, wr_data, tx_done, tx_start, tx_data, count, busy, overflow);
  endtask

  task automatic cyc(input string step, input logic w, input logic [DATA_W-1:0] d, input logic done);
    logic pop, full_b, acc;
    wr_en   = w;
    wr_data = d;
    tx_done = done;
    pop    = !m_send && (q.size() != 0);
    full_b = (q.size() == DEPTH);
    acc    = w && (!full_b || pop);
    @(posedge clk);
    #1;
`ifdef UART_TX_FIFO_OVF_EN
    if (w && full_b && !pop) m_ovf = 1'b1;
`endif
    if (m_send && done && !m_ts) m_send = 1'b0;
    if (pop) begin
      m_data = q.pop_front();
      m_send = 1'b1;
    end
    m_ts = pop;
    if (acc) q.push_back(d);
    check_all(step);
    wr_en   = 1'b0;
    tx_done = 1'b0;
  endtask

  task automatic do_reset(input string step);
    rst     = 1'b1;
    wr_en   = 1'b0;
    tx_done = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_send = 1'b0;
    m_ts   = 1'b0;
    m_data = '0;
    m_ovf  = 1'b0;
    check_all(step);
  endtask

  // Stand-in for uart_tx: answers each frame with tx_done a few cycles after the start pulse.
  task automatic drain(input string step);
    int   k = 0;
    int   wait_c = 0;
    logic dn;
    while ((m_send || q.size() != 0) && k < 2000) begin
      dn = m_send && !m_ts && (wait_c >= 3);
      cyc(step, 1'b0, '0, dn);
      wait_c = dn ? 0 : wait_c + 1;
      k++;
    end
    n_vec++;
    assert (k < 2000) else begin
      n_err++;
      $error("FAIL %s:timeout observed=%0d cycles expected=<2000", step, k);
    end
  endtask

  initial begin
    do_reset("reset");

    // Single byte: start pulse one edge after the write.
    cyc("single_wr", 1'b1, 8'hAA, 1'b0);
    cyc("single_pop", 1'b0, '0, 1'b0);
    chk("single_start_seen", 32'(tx_start), 32'd1);
    chk("single_data_seen", 32'(tx_data), 32'hAA);
    drain("single_drain");
    cyc("single_idle", 1'b0, '0, 1'b0);
    chk("single_busy_low", 32'(busy), 32'd0);

    // Burst of three, then drain in order.
    cyc("burst_w0", 1'b1, 8'h11, 1'b0);
    cyc("burst_w1", 1'b1, 8'h22, 1'b0);
    cyc("burst_w2", 1'b1, 8'h33, 1'b0);
    drain("burst_drain");

    // Overflow: uart_tx never finishes while DEPTH+2 bytes arrive.
    for (int i = 0; i < DEPTH + 2; i++) begin
      cyc("ovf_wr", 1'b1, 8'(i), 1'b0);
    end
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'(DEPTH));
    drain("ovf_drain");

    // Full FIFO in IDLE: write lands on the pop edge.
    cyc("wfull_first", 1'b1, 8'h80, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc("wfull_fill", 1'b1, 8'(8'hC0 + i), 1'b0);
    end
    cyc("wfull_done", 1'b0, '0, 1'b1);
    cyc("wfull_popwr", 1'b1, 8'h5A, 1'b0);
    chk("wfull_count16", 32'(count), 32'(DEPTH));
    drain("wfull_drain");

    // Reset with four bytes queued and a frame in flight.
    for (int i = 0; i < 5; i++) begin
      cyc("rst_fill", 1'b1, 8'(8'h40 + i), 1'b0);
    end
    do_reset("rst_mid");
    cyc("rst_after_done", 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc("rst_quiet", 1'b0, '0, 1'b0);
    end

    // Spurious tx_done: in IDLE while empty, then during the start pulse.
    cyc("spur_idle", 1'b0, '0, 1'b1);
    cyc("spur_wr", 1'b1, 8'h3C, 1'b0);
    cyc("spur_pop", 1'b0, '0, 1'b0);
    cyc("spur_on_start", 1'b0, '0, 1'b1);
    chk("spur_still_busy", 32'(busy), 32'd1);
    cyc("spur_hold", 1'b0, '0, 1'b0);
    drain("spur_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
